// File: rtl/fadd_pkg.sv
// Shared constants and reference arithmetic for the registered ripple-carry adder.
package fadd_pkg;

    localparam int MAX_WIDTH = 64;

    // Reference {c_out, sum} for an adder of the given width; operand bits above width are ignored.
    function automatic logic [MAX_WIDTH:0] ref_sum(
        input logic [MAX_WIDTH-1:0] a,
        input logic [MAX_WIDTH-1:0] b,
        input logic                 c_in,
        input int unsigned          width
    );
        logic [MAX_WIDTH-1:0] mask;
        if (width >= MAX_WIDTH) begin
            mask = {MAX_WIDTH{1'b1}};
        end else begin
            mask = (64'd1 << width) - 64'd1;
        end
        return {1'b0, a & mask} + {1'b0, b & mask} + {{MAX_WIDTH{1'b0}}, c_in};
    endfunction

endpackage

// File: rtl/fa_if.sv
// Operand/result bundle for full_adder_top with driver and DUT views.
interface fa_if #(
    parameter int WIDTH = 1
) (
    input logic clk,
    input logic rst_n
);
    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             ovf;
    logic             out_valid;

    modport drv (
        input  clk, rst_n, sum, c_out, ovf, out_valid,
        output in_valid, a, b, c_in
    );

    modport dut (
        input  clk, rst_n, in_valid, a, b, c_in,
        output sum, c_out, ovf, out_valid
    );
endinterface

// File: rtl/full_adder_cell.sv
// One bit of the ripple-carry chain: purely combinational full adder.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/full_adder_top.sv
// Parameterised ripple-carry adder with optional one-cycle output register stage.
module full_adder_top
    import fadd_pkg::*;
#(
    parameter int WIDTH        = 1,
    parameter bit PASS_THROUGH = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf,
    output logic             out_valid
);
    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             c_out;
        logic             ovf;
    } result_t;

    logic [WIDTH:0]   carry_s;
    logic [WIDTH-1:0] sum_s;
    result_t          comb_s;

    assign carry_s[0] = c_in;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chain
        full_adder_cell u_cell (
            .a    (a[gi]),
            .b    (b[gi]),
            .cin  (carry_s[gi]),
            .s    (sum_s[gi]),
            .cout (carry_s[gi+1])
        );
    end

    // Signed overflow: carry into the MSB disagrees with carry out of it.
    assign comb_s.sum   = sum_s;
    assign comb_s.c_out = carry_s[WIDTH];
    assign comb_s.ovf   = carry_s[WIDTH-1] ^ carry_s[WIDTH];

    if (PASS_THROUGH) begin : g_comb
        assign sum       = comb_s.sum;
        assign c_out     = comb_s.c_out;
        assign ovf       = comb_s.ovf;
        assign out_valid = in_valid;
    end else begin : g_reg
        result_t res_r;
        logic    valid_r;

        // Result capture: only a valid cycle loads, so idle operands never reach the outputs.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                res_r   <= '0;
                valid_r <= 1'b0;
            end else begin
                valid_r <= in_valid;
                if (in_valid) begin
                    res_r <= comb_s;
                end else begin
                    res_r <= res_r;
                end
            end
        end

        assign sum       = res_r.sum;
        assign c_out     = res_r.c_out;
        assign ovf       = res_r.ovf;
        assign out_valid = valid_r;
    end

endmodule

// File: tb/tb_full_adder_top.sv
// Directed and randomized checks of full_adder_top at widths 1, 8 and 16 plus a pass-through instance.
module tb_full_adder_top;
    import fadd_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    fa_if #(.WIDTH(1))  bus1  (.clk(clk), .rst_n(rst_n));
    fa_if #(.WIDTH(8))  bus8  (.clk(clk), .rst_n(rst_n));
    fa_if #(.WIDTH(16)) bus16 (.clk(clk), .rst_n(rst_n));

    logic [7:0] pt_sum;
    logic       pt_c_out, pt_ovf, pt_out_valid;

    full_adder_top #(.WIDTH(1), .PASS_THROUGH(1'b0)) u_w1 (
        .clk(clk), .rst_n(rst_n), .in_valid(bus1.in_valid), .a(bus1.a), .b(bus1.b),
        .c_in(bus1.c_in), .sum(bus1.sum), .c_out(bus1.c_out), .ovf(bus1.ovf),
        .out_valid(bus1.out_valid));

    full_adder_top #(.WIDTH(8), .PASS_THROUGH(1'b0)) u_w8 (
        .clk(clk), .rst_n(rst_n), .in_valid(bus8.in_valid), .a(bus8.a), .b(bus8.b),
        .c_in(bus8.c_in), .sum(bus8.sum), .c_out(bus8.c_out), .ovf(bus8.ovf),
        .out_valid(bus8.out_valid));

    full_adder_top #(.WIDTH(8), .PASS_THROUGH(1'b1)) u_pt (
        .clk(clk), .rst_n(rst_n), .in_valid(bus8.in_valid), .a(bus8.a), .b(bus8.b),
        .c_in(bus8.c_in), .sum(pt_sum), .c_out(pt_c_out), .ovf(pt_ovf),
        .out_valid(pt_out_valid));

    full_adder_top #(.WIDTH(16), .PASS_THROUGH(1'b0)) u_w16 (
        .clk(clk), .rst_n(rst_n), .in_valid(bus16.in_valid), .a(bus16.a), .b(bus16.b),
        .c_in(bus16.c_in), .sum(bus16.sum), .c_out(bus16.c_out), .ovf(bus16.ovf),
        .out_valid(bus16.out_valid));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: unsigned result from the package function, overflow from signed integer range.
    function automatic void model(input int w, input logic [63:0] a, input logic [63:0] b,
                                  input logic c, output logic [63:0] s, output logic co,
                                  output logic ov);
        logic [64:0] r;
        longint      half, sa, sb, st;
        r    = ref_sum(a, b, c, w);
        half = longint'(1) << (w - 1);
        sa   = (longint'(a) >= half) ? longint'(a) - 2 * half : longint'(a);
        sb   = (longint'(b) >= half) ? longint'(b) - 2 * half : longint'(b);
        st   = sa + sb + longint'(c);
        s    = r[63:0] & ((64'd1 << w) - 64'd1);
        co   = r[w];
        ov   = (st >= half) || (st < -half);
    endfunction

    typedef struct {
        logic [7:0] a, b;
        logic       c;
        logic [7:0] s;
        logic       co, ov;
    } vec8_t;

    vec8_t vecs[3] = '{
        '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0},
        '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1},
        '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0}
    };

    initial begin
        logic [63:0] es;
        logic        eco, eov, ev;
        logic [2:0]  abc;
        logic [15:0] ra, rb;
        logic        rc, riv;
        int          total;

        rst_n = 1'b0;
        bus1.in_valid = 1'b1; bus1.a = 1'b1; bus1.b = 1'b1; bus1.c_in = 1'b1;
        bus8.in_valid = 1'b1; bus8.a = 8'h12; bus8.b = 8'h34; bus8.c_in = 1'b0;
        bus16.in_valid = 1'b0; bus16.a = 16'h0; bus16.b = 16'h0; bus16.c_in = 1'b0;

        // Reset held across three edges with valid operands present.
        repeat (3) begin
            @(posedge clk); #1;
            chk("rst_sum", 64'(bus1.sum), 64'd0);
            chk("rst_cout", 64'(bus1.c_out), 64'd0);
            chk("rst_valid", 64'(bus1.out_valid), 64'd0);
        end
        chk("pt_rst_sum", 64'(pt_sum), 64'h46);
        chk("pt_rst_valid", 64'(pt_out_valid), 64'd1);

        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rel_sum", 64'(bus1.sum), 64'd1);
        chk("rel_cout", 64'(bus1.c_out), 64'd1);
        chk("rel_valid", 64'(bus1.out_valid), 64'd1);
        chk("rel_sum8", 64'(bus8.sum), 64'h46);

        // Exhaustive 1-bit.
        for (int i = 0; i < 8; i++) begin
            abc = 3'(i);
            bus1.a = abc[2]; bus1.b = abc[1]; bus1.c_in = abc[0];
            @(posedge clk); #1;
            total = int'(abc[2]) + int'(abc[1]) + int'(abc[0]);
            chk("ex1_sum", 64'(bus1.sum), 64'(total % 2));
            chk("ex1_cout", 64'(bus1.c_out), 64'(total / 2));
            chk("ex1_ovf", 64'(bus1.ovf), 64'(abc[0] ^ (total >= 2)));
        end
        bus1.in_valid = 1'b0;

        // 8-bit boundaries, registered and pass-through.
        for (int i = 0; i < 3; i++) begin
            bus8.a = vecs[i].a; bus8.b = vecs[i].b; bus8.c_in = vecs[i].c;
            #1;
            chk("pt_sum", 64'(pt_sum), 64'(vecs[i].s));
            chk("pt_cout", 64'(pt_c_out), 64'(vecs[i].co));
            chk("pt_ovf", 64'(pt_ovf), 64'(vecs[i].ov));
            @(posedge clk); #1;
            chk("b8_sum", 64'(bus8.sum), 64'(vecs[i].s));
            chk("b8_cout", 64'(bus8.c_out), 64'(vecs[i].co));
            chk("b8_ovf", 64'(bus8.ovf), 64'(vecs[i].ov));
        end

        // Hold: one valid result, then idle cycles with junk operands.
        bus8.a = 8'd3; bus8.b = 8'd4; bus8.c_in = 1'b0;
        @(posedge clk); #1;
        chk("hold_load", 64'(bus8.sum), 64'd7);
        chk("hold_load_v", 64'(bus8.out_valid), 64'd1);
        bus8.in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus8.a = (i == 0) ? 8'hxx : 8'($urandom());
            bus8.b = 8'($urandom());
            bus8.c_in = (i == 1) ? 1'bx : 1'($urandom());
            @(posedge clk); #1;
            chk("hold_sum", 64'(bus8.sum), 64'd7);
            chk("hold_cout", 64'(bus8.c_out), 64'd0);
            chk("hold_valid", 64'(bus8.out_valid), 64'd0);
        end
        chk("pt_valid_idle", 64'(pt_out_valid), 64'd0);

        // Back-to-back 16-bit traffic interrupted by an asynchronous reset.
        bus16.in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ra = 16'($urandom()); rb = 16'($urandom()); rc = 1'($urandom());
            bus16.a = ra; bus16.b = rb; bus16.c_in = rc;
            @(posedge clk); #1;
            model(16, 64'(ra), 64'(rb), rc, es, eco, eov);
            chk("b2b_sum", 64'(bus16.sum), es);
            chk("b2b_cout", 64'(bus16.c_out), 64'(eco));
        end
        bus16.a = 16'hFFFF; bus16.b = 16'hFFFF; bus16.c_in = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("ar_sum", 64'(bus16.sum), 64'd0);
        chk("ar_cout", 64'(bus16.c_out), 64'd0);
        chk("ar_ovf", 64'(bus16.ovf), 64'd0);
        chk("ar_valid", 64'(bus16.out_valid), 64'd0);
        @(posedge clk); #1;
        chk("ar_hold_valid", 64'(bus16.out_valid), 64'd0);
        rst_n = 1'b1;
        ra = 16'h8000; rb = 16'h8000; rc = 1'b0;
        bus16.a = ra; bus16.b = rb; bus16.c_in = rc;
        @(posedge clk); #1;
        model(16, 64'(ra), 64'(rb), rc, es, eco, eov);
        chk("ar_rel_sum", 64'(bus16.sum), es);
        chk("ar_rel_cout", 64'(bus16.c_out), 64'(eco));
        chk("ar_rel_ovf", 64'(bus16.ovf), 64'(eov));
        chk("ar_rel_valid", 64'(bus16.out_valid), 64'd1);

        // Random traffic with a scoreboard that holds the last valid result.
        for (int i = 0; i < 10000; i++) begin
            riv = 1'($urandom());
            ra = 16'($urandom()); rb = 16'($urandom()); rc = 1'($urandom());
            bus16.in_valid = riv; bus16.a = ra; bus16.b = rb; bus16.c_in = rc;
            if (riv) begin
                model(16, 64'(ra), 64'(rb), rc, es, eco, eov);
            end
            ev = riv;
            @(posedge clk); #1;
            chk("rnd_sum", 64'(bus16.sum), es);
            chk("rnd_cout", 64'(bus16.c_out), 64'(eco));
            chk("rnd_ovf", 64'(bus16.ovf), 64'(eov));
            chk("rnd_valid", 64'(bus16.out_valid), 64'(ev));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
